// File: rtl/cdb_scheduler_if.sv
// cdb_scheduler_if
//   Bundle of the request/grant and bus-select signals exchanged between the
//   CDB scheduler and its surroundings (execution combos and ROB).
//   NUM_REQ must match the NUM_REQ of the attached cdb_scheduler.
//
//   Signals:
//     i_flush      pipeline flush, drops pending grants
//     i_req        per-requester "finished result held" flags
//     i_bus_busy   per-bus backpressure from the ROB
//     o_grant      per-requester 1-cycle grant pulse
//     o_bus_index  per-requester granted bus (valid with o_grant)
//     o_select0/1  owner address of CDB 0/1, or the idle address
//     o_bus_valid  per-bus "carries a granted result" flag
//
//   Modports:
//     master  drives the requests/backpressure (combos, ROB, testbench)
//     slave   the scheduler itself
interface cdb_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic               i_flush;
    logic [NUM_REQ-1:0] i_req;
    logic [1:0]         i_bus_busy;
    logic [NUM_REQ-1:0] o_grant;
    logic [NUM_REQ-1:0] o_bus_index;
    logic [7:0]         o_select0;
    logic [7:0]         o_select1;
    logic [1:0]         o_bus_valid;

    modport master (
        output i_flush, i_req, i_bus_busy,
        input  o_grant, o_bus_index, o_select0, o_select1, o_bus_valid
    );

    modport slave (
        input  i_flush, i_req, i_bus_busy,
        output o_grant, o_bus_index, o_select0, o_select1, o_bus_valid
    );
endinterface

// File: rtl/cdb_scheduler.sv
// cdb_scheduler
//   Central registered round-robin arbiter for the two common data buses.
//   Each cycle it picks up to two eligible requesters (one per free bus),
//   scanning from rr_ptr, and presents the grant one cycle later, which is
//   the cycle in which the winning combo drives the bus.
//
//   Ports:
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    cdb_scheduler_if slave modport (requests, backpressure, flush,
//            grants, bus indices, per-bus select addresses and valids)
//
//   Parameters:
//     NUM_REQ    number of requesters, 2..8
//     ADDR_BASE  select address of requester 0 (requester i owns ADDR_BASE+i)
//     IDLE_ADDR  select value for an unowned bus, outside the owned range
module cdb_scheduler #(
    parameter int         NUM_REQ   = 4,
    parameter logic [7:0] ADDR_BASE = 8'h00,
    parameter logic [7:0] IDLE_ADDR = 8'hFF
) (
    input  logic           clk,
    input  logic           reset,
    cdb_scheduler_if.slave bus
);

    localparam int             IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] bus_index_q, bus_index_d;
    logic [7:0]         select0_q, select0_d;
    logic [7:0]         select1_q, select1_d;
    logic [1:0]         bus_valid_q, bus_valid_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0] eligible;
    logic [1:0]         bus_free;
    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   first_idx, second_idx;
    logic               first_found, second_found;

    // (base + off) mod NUM_REQ; base < NUM_REQ and off <= NUM_REQ, so a
    // single conditional subtract is enough.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                   input int unsigned      off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + (IDX_W + 1)'(off);
        if (sum >= NUM_REQ_W) begin
            sum = sum - NUM_REQ_W;
        end
        return sum[IDX_W-1:0];
    endfunction

    function automatic logic [7:0] owner_addr(input logic [IDX_W-1:0] idx);
        return ADDR_BASE + {{(8 - IDX_W){1'b0}}, idx};
    endfunction

    // A requester granted last cycle is driving the bus right now; masking it
    // here keeps a held-high request from being granted twice for one result.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            assign eligible[gi] = bus.i_req[gi] & ~grant_q[gi];
        end
    endgenerate

    assign bus_free = ~bus.i_bus_busy;

    // Find the first and second eligible requesters in round-robin order.
    always_comb begin
        first_found  = 1'b0;
        second_found = 1'b0;
        first_idx    = '0;
        second_idx   = '0;
        scan_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = wrap_add(rr_ptr_q, k);
            if (eligible[scan_idx]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = scan_idx;
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = scan_idx;
                end
            end
        end
    end

    // Bus assignment. The first winner takes bus 0 when it is free, otherwise
    // bus 1; the second winner only gets a bus when both are free, so one
    // requester can never hold both buses.
    always_comb begin
        grant_d     = '0;
        bus_index_d = '0;
        select0_d   = IDLE_ADDR;
        select1_d   = IDLE_ADDR;
        bus_valid_d = 2'b00;
        rr_ptr_d    = rr_ptr_q;

        if (bus.i_flush) begin
            rr_ptr_d = '0;
        end else if (first_found) begin
            if (bus_free[0]) begin
                grant_d[first_idx] = 1'b1;
                select0_d          = owner_addr(first_idx);
                bus_valid_d[0]     = 1'b1;
                rr_ptr_d           = wrap_add(first_idx, 1);
                if (bus_free[1] && second_found) begin
                    grant_d[second_idx]     = 1'b1;
                    bus_index_d[second_idx] = 1'b1;
                    select1_d               = owner_addr(second_idx);
                    bus_valid_d[1]          = 1'b1;
                    rr_ptr_d                = wrap_add(second_idx, 1);
                end
            end else if (bus_free[1]) begin
                grant_d[first_idx]     = 1'b1;
                bus_index_d[first_idx] = 1'b1;
                select1_d              = owner_addr(first_idx);
                bus_valid_d[1]         = 1'b1;
                rr_ptr_d               = wrap_add(first_idx, 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q     <= '0;
            bus_index_q <= '0;
            select0_q   <= IDLE_ADDR;
            select1_q   <= IDLE_ADDR;
            bus_valid_q <= 2'b00;
            rr_ptr_q    <= '0;
        end else begin
            grant_q     <= grant_d;
            bus_index_q <= bus_index_d;
            select0_q   <= select0_d;
            select1_q   <= select1_d;
            bus_valid_q <= bus_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.o_grant     = grant_q;
    assign bus.o_bus_index = bus_index_q;
    assign bus.o_select0   = select0_q;
    assign bus.o_select1   = select1_q;
    assign bus.o_bus_valid = bus_valid_q;

endmodule

// File: tb/tb_cdb_scheduler.sv
// tb_cdb_scheduler
//   Directed testbench for cdb_scheduler. Instance A uses ADDR_BASE=8'h00,
//   instance B uses ADDR_BASE=8'h10; both have NUM_REQ=4, IDLE_ADDR=8'hFF.
//   Inputs change 1 time unit after a rising edge; outputs are checked at
//   that same point, i.e. they reflect the decision made at that edge.
module tb_cdb_scheduler;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cdb_scheduler_if #(.NUM_REQ(4)) if_a ();
    cdb_scheduler_if #(.NUM_REQ(4)) if_b ();

    cdb_scheduler #(.NUM_REQ(4), .ADDR_BASE(8'h00), .IDLE_ADDR(8'hFF)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (if_a)
    );

    cdb_scheduler #(.NUM_REQ(4), .ADDR_BASE(8'h10), .IDLE_ADDR(8'hFF)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (if_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic [3:0] g, input logic [3:0] idx,
                           input logic [7:0] s0, input logic [7:0] s1, input logic [1:0] v);
        cmp({tag, ".grant"},  {4'h0, if_a.o_grant},     {4'h0, g});
        cmp({tag, ".index"},  {4'h0, if_a.o_bus_index}, {4'h0, idx});
        cmp({tag, ".sel0"},   if_a.o_select0,           s0);
        cmp({tag, ".sel1"},   if_a.o_select1,           s1);
        cmp({tag, ".valid"},  {6'h0, if_a.o_bus_valid}, {6'h0, v});
        $display("A %-14s req=%b busy=%b flush=%b -> grant=%b idx=%b sel0=%h sel1=%h valid=%b",
                 tag, if_a.i_req, if_a.i_bus_busy, if_a.i_flush, if_a.o_grant,
                 if_a.o_bus_index, if_a.o_select0, if_a.o_select1, if_a.o_bus_valid);
    endtask

    task automatic check_b(input string tag, input logic [3:0] g, input logic [3:0] idx,
                           input logic [7:0] s0, input logic [7:0] s1, input logic [1:0] v);
        cmp({tag, ".grant"},  {4'h0, if_b.o_grant},     {4'h0, g});
        cmp({tag, ".index"},  {4'h0, if_b.o_bus_index}, {4'h0, idx});
        cmp({tag, ".sel0"},   if_b.o_select0,           s0);
        cmp({tag, ".sel1"},   if_b.o_select1,           s1);
        cmp({tag, ".valid"},  {6'h0, if_b.o_bus_valid}, {6'h0, v});
        $display("B %-14s req=%b rst=%b -> grant=%b idx=%b sel0=%h sel1=%h valid=%b",
                 tag, if_b.i_req, rst_b, if_b.o_grant, if_b.o_bus_index,
                 if_b.o_select0, if_b.o_select1, if_b.o_bus_valid);
    endtask

    initial begin
        rst_a           = 1'b1;
        rst_b           = 1'b1;
        if_a.i_flush    = 1'b0;
        if_a.i_req      = 4'b0000;
        if_a.i_bus_busy = 2'b00;
        if_b.i_flush    = 1'b0;
        if_b.i_req      = 4'b0000;
        if_b.i_bus_busy = 2'b00;
        step();
        step();
        check_a("reset", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        check_b("reset", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            step();
            check_a("idle", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        end

        // Two sparse requesters, both buses free; rr_ptr -> 3.
        if_a.i_req = 4'b0101;
        step();
        check_a("req0101", 4'b0101, 4'b0100, 8'h00, 8'h02, 2'b11);
        step();
        check_a("req0101_mask", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        if_a.i_req = 4'b0000;
        step();
        check_a("req_drop", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);

        // Flush with rr_ptr=3 must bring it back to 0.
        if_a.i_flush = 1'b1;
        step();
        check_a("flush1", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        if_a.i_flush = 1'b0;

        // All four requesting: pairs {0,1} and {2,3} alternate.
        if_a.i_req = 4'b1111;
        step();
        check_a("all_p01_a", 4'b0011, 4'b0010, 8'h00, 8'h01, 2'b11);
        step();
        check_a("all_p23_a", 4'b1100, 4'b1000, 8'h02, 8'h03, 2'b11);
        step();
        check_a("all_p01_b", 4'b0011, 4'b0010, 8'h00, 8'h01, 2'b11);
        step();
        check_a("all_p23_b", 4'b1100, 4'b1000, 8'h02, 8'h03, 2'b11);
        if_a.i_req = 4'b0000;
        step();
        check_a("all_end", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);

        // Bus 0 busy: the single requester lands on bus 1; rr_ptr -> 2.
        if_a.i_bus_busy = 2'b01;
        if_a.i_req      = 4'b0010;
        step();
        check_a("busy01", 4'b0010, 4'b0010, 8'hFF, 8'h01, 2'b10);
        if_a.i_req = 4'b0000;

        // Both busy: request stays pending until a bus frees up.
        if_a.i_bus_busy = 2'b11;
        if_a.i_req      = 4'b0010;
        step();
        check_a("busy11_a", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        step();
        check_a("busy11_b", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        if_a.i_bus_busy = 2'b00;
        step();
        check_a("busy_clear", 4'b0010, 4'b0000, 8'h01, 8'hFF, 2'b01);
        if_a.i_req = 4'b0000;
        step();
        check_a("busy_end", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);

        // Flush in the same cycle as a request: request ignored.
        if_a.i_req   = 4'b1000;
        if_a.i_flush = 1'b1;
        step();
        check_a("flush_req", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        if_a.i_flush = 1'b0;
        step();
        check_a("post_flush", 4'b1000, 4'b0000, 8'h03, 8'hFF, 2'b01);
        if_a.i_req = 4'b0000;
        step();
        check_a("post_flush_end", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);

        // Only bus 0 free, everyone requesting: one grant per cycle, rotating.
        if_a.i_bus_busy = 2'b10;
        if_a.i_req      = 4'b1111;
        step();
        check_a("single_r0", 4'b0001, 4'b0000, 8'h00, 8'hFF, 2'b01);
        step();
        check_a("single_r1", 4'b0010, 4'b0000, 8'h01, 8'hFF, 2'b01);
        step();
        check_a("single_r2", 4'b0100, 4'b0000, 8'h02, 8'hFF, 2'b01);
        step();
        check_a("single_r3", 4'b1000, 4'b0000, 8'h03, 8'hFF, 2'b01);
        if_a.i_req      = 4'b0000;
        if_a.i_bus_busy = 2'b00;
        step();
        check_a("single_end", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);

        // Instance B: reset coincides with the requests.
        if_b.i_req = 4'b0011;
        rst_b      = 1'b1;
        step();
        check_b("rst_mid", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);
        rst_b = 1'b0;
        step();
        check_b("base10", 4'b0011, 4'b0010, 8'h10, 8'h11, 2'b11);
        if_b.i_req = 4'b0000;
        step();
        check_b("base10_end", 4'b0000, 4'b0000, 8'hFF, 8'hFF, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
